// File: rtl/timestamp_readout_arbiter.sv
// timestamp_readout_arbiter
// Merges the 32-bit readout FIFO streams of N_SRC timestamp cores into a
// single FIFO-style stream. Sources are served round-robin; a 3-word
// timestamp record (type nibble [27:24] = 1, 2, 3) is kept atomic by
// locking the grant on the source that delivered the record head.
// The output side is a one-entry register that can be refilled in the same
// cycle it is read, so the merged stream sustains one word per cycle.
//
// Optional feature (compile-time macro TS_ARB_LOCK_TIMEOUT_EN):
//   defined   - a locked source that stays empty for TIMEOUT cycles is
//               forcibly released and the event counts as a sequence error.
//   undefined - a locked source is waited for indefinitely.

module timestamp_readout_arbiter #(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [N_SRC-1:0]     SRC_FIFO_EMPTY,
  output logic [N_SRC-1:0]     SRC_FIFO_READ,
  input  logic [32*N_SRC-1:0]  SRC_FIFO_DATA,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA,
  output logic [N_SRC-1:0]     GRANT,
  output logic                 LOCKED,
  output logic [7:0]           SEQ_ERR_CNT
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [3:0] TYPE_HEAD = 4'h1;
  localparam logic [3:0] TYPE_BODY = 4'h2;
  localparam logic [3:0] TYPE_TAIL = 4'h3;

  // Parameter sanity checks, evaluated at elaboration only.
  if (N_SRC < 2 || N_SRC > 8) begin : g_bad_n_src
    $error("timestamp_readout_arbiter: N_SRC must lie in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("timestamp_readout_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Saturating increment for the 8-bit error counter: holds at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [7:0]       err_cnt_q;

  // ------------------------------------------------------------------
  // Pop-side signals
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] src_word [N_SRC];
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_vld;
  logic [PTR_W-1:0]  pop_idx;
  logic              pop_en;
  logic [DATA_W-1:0] pop_word;
  logic [3:0]        pop_type;
  logic              load_ok;
  logic              seq_err;
  logic              timeout_hit;

  // ------------------------------------------------------------------
  // Output buffer (one entry)
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] out_data_p1;
  logic              out_vld_p1;

  // Unpack the flat source data bus into one word per source.
  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_word[i] = SRC_FIFO_DATA[DATA_W*i +: DATA_W];
  end

  // The buffer accepts a new word when it is empty, or when its current
  // word leaves downstream in this same cycle.
  assign load_ok = !out_vld_p1 || FIFO_READ;

  // Round-robin candidate: first non-empty source strictly after rr_ptr,
  // wrapping modulo N_SRC.
  always_comb begin
    logic [PTR_W:0]   cand;
    logic [PTR_W-1:0] cand_idx;
    sel_idx  = '0;
    sel_vld  = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_SRC)) begin
        cand = cand - (PTR_W+1)'(N_SRC);
      end
      cand_idx = cand[PTR_W-1:0];
      if (!sel_vld && !SRC_FIFO_EMPTY[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  // While idle the round-robin candidate is popped; while locked only the
  // granted source may be popped, every other source waits.
  assign pop_idx  = (state_q == ST_IDLE) ? sel_idx : gnt_idx_q;
  assign pop_en   = load_ok && ((state_q == ST_IDLE) ? sel_vld
                                                     : !SRC_FIFO_EMPTY[gnt_idx_q]);
  assign pop_word = src_word[pop_idx];
  assign pop_type = pop_word[27:24];

`ifdef TS_ARB_LOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_run;

  // The counter only advances while a record is open and its source has
  // nothing to give; any pop (which needs a non-empty source) clears it.
  assign tmo_run     = (state_q == ST_LOCKED) && SRC_FIFO_EMPTY[gnt_idx_q];
  assign timeout_hit = tmo_run && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  // Lock starvation counter.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_run || timeout_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  // Without the timeout a locked source is waited for forever.
  assign timeout_hit = 1'b0;
`endif

  // State register: FSM state, round-robin pointer, granted index.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= PTR_W'(N_SRC - 1);
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  // Next-state logic: decode the type of the word being popped.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    seq_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop_en) begin
          if (pop_type == TYPE_HEAD) begin
            state_d   = ST_LOCKED;
            gnt_idx_d = sel_idx;
          end else begin
            // Stray single word: forwarded on its own, counts as served.
            rr_ptr_d = sel_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (pop_en) begin
          if (pop_type == TYPE_TAIL) begin
            state_d  = ST_IDLE;
            rr_ptr_d = gnt_idx_q;
          end else if (pop_type != TYPE_BODY) begin
            // A second head or an unknown type inside a record is still
            // forwarded, but the record is flagged as malformed.
            seq_err = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d  = ST_IDLE;
          rr_ptr_d = gnt_idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: pop strobe, grant vector and lock flag.
  always_comb begin
    SRC_FIFO_READ = '0;
    GRANT         = '0;
    LOCKED        = (state_q == ST_LOCKED);
    if (pop_en && BUS_RST_N) begin
      SRC_FIFO_READ[pop_idx] = 1'b1;
    end
    if (state_q == ST_LOCKED) begin
      GRANT[gnt_idx_q] = 1'b1;
    end
  end

  // Sequence-error counter, saturating at 255.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      err_cnt_q <= '0;
    end else if (seq_err || timeout_hit) begin
      err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  // Output buffer: a pop overwrites the entry (also while it is being read),
  // otherwise a downstream read drains it. Reads of an empty buffer do nothing.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
    end else if (pop_en) begin
      out_vld_p1  <= 1'b1;
      out_data_p1 <= pop_word;
    end else if (FIFO_READ) begin
      out_vld_p1  <= 1'b0;
    end
  end

  assign FIFO_EMPTY  = !out_vld_p1;
  assign FIFO_DATA   = out_data_p1;
  assign SEQ_ERR_CNT = err_cnt_q;

endmodule
